shared_bus_arbiter: RTL and testbench
=====================================

Name: shared_bus_arbiter

Overview:
- Round-robin arbiter that shares one 10-bit bidirectional module bus (tri-state port) between N requesters.
- Grants one owner at a time and drives the bus output-enable and write data for that owner.
- Inserts mandatory turnaround (undriven) cycles between owners and preempts any owner exceeding a hold limit.
- Sits beside the bus module; the top level ties o_bus_oe/o_bus_data onto the inout tri port.

Parameters:
- N, 4, number of requesters; legal range 2..16.
- W, 10, bus data width.
- TURN_CYCLES, 1, undriven cycles between consecutive owners; must be >= 1.
- MAX_HOLD, 16, maximum consecutive granted cycles per owner; must be >= 2.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  reset; asynchronous, active-high.
- i_req  input  N  per-requester bus request; held high while the requester wants the bus.
- i_last  input  N  per-requester final beat marker, sampled only while that requester is granted.
- i_wdata  input  N*W  per-requester write data; slice k is bits [k*W +: W].
- o_gnt  output  N  one-hot grant, registered.
- o_bus_oe  output  1  bus output enable, registered.
- o_bus_data  output  W  data to drive onto the bus.
- o_owner  output  $clog2(N)  index of the current or most recent owner.
- o_preempt  output  1  one-cycle pulse when an owner is released by the hold limit.
- o_busy  output  1  high in GRANT and TURN states.

Behaviour:
- Reset values:
  - o_gnt=0, o_bus_oe=0, o_bus_data=0, o_owner=0, o_preempt=0, o_busy=0.
  - State IDLE; priority pointer ptr=0; hold counter=0; turn counter=0.
- Reset asserted mid-grant: o_bus_oe drops asynchronously and the bus is released immediately.
- Arbitration:
  - Select the first k with i_req[k]=1, searching circularly from ptr upward.
  - Arbitration runs in IDLE and in the final TURN cycle.
- IDLE:
  - If any i_req is set at edge t, enter GRANT at t+1 with o_gnt=onehot(k), o_bus_oe=1, o_owner=k, hold=0.
  - Latency from request to grant is 1 cycle.
- GRANT:
  - o_bus_data = i_wdata[o_owner], combinational from the registered owner; it is 0 when o_bus_oe=0.
  - A beat is a cycle in which o_gnt[k] and i_req[k] are both high.
  - hold increments on every GRANT cycle.
  - Release conditions, evaluated at each edge:
    - (a) i_last[owner] and i_req[owner] both high: normal end.
    - (b) i_req[owner] low: abandon; that cycle carries no beat.
    - (c) hold == MAX_HOLD-1: forced release; o_preempt=1 for the next cycle.
  - On release the next cycle has o_gnt=0, o_bus_oe=0, ptr=(owner+1) mod N, state TURN, turn=TURN_CYCLES-1.
  - Simultaneous (a) and (c): treat as normal end; o_preempt stays 0.
- TURN:
  - The bus is undriven for exactly TURN_CYCLES cycles.
  - turn decrements each cycle.
  - In the cycle where turn==0, arbitrate: with any request, go to GRANT next cycle; otherwise go to IDLE.
  - Back-to-back owners therefore have exactly TURN_CYCLES dead cycles between them.
- Fairness:
  - A preempted owner goes last in priority and may regain the bus only after the other active requesters are served.
  - A sole requester may regain the bus after the turnaround.
- Invariants:
  - o_gnt is zero or one-hot.
  - o_bus_oe == |o_gnt.
  - o_bus_oe is never high in two different owners' cycles without TURN_CYCLES gaps between them.
- Widths:
  - hold is $clog2(MAX_HOLD) bits and does not wrap past MAX_HOLD-1.
  - ptr wraps from N-1 to 0.

Decomposition:
- Package shared_bus_pkg holds:
  - state enum {IDLE, GRANT, TURN};
  - the default bus width constant (10);
  - a function computing onehot from an index.
- One combinational sub-module, rr_pick:
  - inputs: N-bit request vector and ptr;
  - outputs: valid and selected index (circular first-set search).

Test Plan:
- Reset with i_req=4'b1111, then release reset → o_gnt=4'b0001 one cycle after the first edge; o_bus_oe=1; o_bus_data=i_wdata[0].
- Requester 0 asserts i_last on its 3rd beat with i_req=4'b0101 → o_gnt=0 for 1 cycle (TURN_CYCLES=1), then o_gnt=4'b0100; o_owner=2.
- Requester 1 holds i_req with no i_last and MAX_HOLD=16 → exactly 16 granted cycles, then o_preempt=1 for 1 cycle; o_gnt=0; next owner is 2 if it is requesting.
- Owner 3 drops i_req mid-transfer → release at the next edge; ptr=0; o_bus_oe=0 for TURN_CYCLES cycles.
- Assert i_rst in the 2nd cycle of a grant → o_bus_oe and o_gnt go to 0 immediately without a clock edge; after release, arbitration restarts from ptr=0.
- TURN_CYCLES=3 with continuous requests from all 4 requesters → grants rotate 0,1,2,3,0 with exactly 3 dead cycles between grants.

Source files
------------

// File: rtl/shared_bus_pkg.sv
// Shared definitions for the round-robin bus arbiter: FSM states, default bus
// width and the index-to-onehot helper.
package shared_bus_pkg;

    localparam int unsigned BUS_W_DEFAULT = 10;
    localparam int unsigned MAX_REQ       = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_TURN  = 2'd2
    } state_e;

    function automatic logic [MAX_REQ-1:0] onehot(input logic [3:0] idx);
        onehot      = '0;
        onehot[idx] = 1'b1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Circular first-set search: returns the first requester at or above i_ptr,
// wrapping from N-1 back to 0.
module rr_pick #(
    parameter int unsigned N = 4,
    localparam int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic          o_valid,
    output logic [IW-1:0] o_idx
);

    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!o_valid && i_req[IW'((32'(i_ptr) + i) % N)]) begin
                o_valid = 1'b1;
                o_idx   = IW'((32'(i_ptr) + i) % N);
            end
        end
    end

endmodule

// File: rtl/shared_bus_arbiter.sv
// Round-robin owner selection for a shared tri-state bus, with mandatory
// undriven turnaround cycles between owners and a per-owner hold limit.
//
// state    | meaning
// ST_IDLE  | no owner, arbitrate every cycle
// ST_GRANT | owner drives the bus; watch last/abandon/hold limit
// ST_TURN  | bus undriven for TURN_CYCLES; arbitrate in the final cycle
module shared_bus_arbiter
    import shared_bus_pkg::*;
#(
    parameter int unsigned N           = 4,
    parameter int unsigned W           = BUS_W_DEFAULT,
    parameter int unsigned TURN_CYCLES = 1,
    parameter int unsigned MAX_HOLD    = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [N-1:0]         i_req,
    input  logic [N-1:0]         i_last,
    input  logic [N*W-1:0]       i_wdata,
    output logic [N-1:0]         o_gnt,
    output logic                 o_bus_oe,
    output logic [W-1:0]         o_bus_data,
    output logic [$clog2(N)-1:0] o_owner,
    output logic                 o_preempt,
    output logic                 o_busy
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned HW = $clog2(MAX_HOLD);
    localparam int unsigned TW = (TURN_CYCLES > 1) ? $clog2(TURN_CYCLES) : 1;

    state_e        state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [TW-1:0] turn_q, turn_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic          oe_q, oe_d;
    logic          preempt_q, preempt_d;

    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic          own_req, own_last, hold_max, do_release, do_grant;

    rr_pick #(.N(N)) u_pick (
        .i_req   (i_req),
        .i_ptr   (ptr_q),
        .o_valid (pick_valid),
        .o_idx   (pick_idx)
    );

    assign own_req    = i_req[owner_q];
    assign own_last   = i_last[owner_q];
    assign hold_max   = (hold_q == HW'(MAX_HOLD - 1));
    assign do_release = (state_q == ST_GRANT) && (!own_req || own_last || hold_max);
    assign do_grant   = pick_valid &&
                        ((state_q == ST_IDLE) || ((state_q == ST_TURN) && (turn_q == '0)));

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        owner_d   = owner_q;
        hold_d    = hold_q;
        turn_d    = turn_q;
        gnt_d     = gnt_q;
        oe_d      = oe_q;
        preempt_d = 1'b0;

        case (state_q)
            ST_IDLE: ;
            ST_GRANT: begin
                if (do_release) begin
                    state_d   = ST_TURN;
                    gnt_d     = '0;
                    oe_d      = 1'b0;
                    ptr_d     = (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;
                    turn_d    = TW'(TURN_CYCLES - 1);
                    // only the hold limit can release an owner still requesting without last
                    preempt_d = own_req && !own_last;
                end else if (!hold_max) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            ST_TURN: begin
                if (turn_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    turn_d = turn_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (do_grant) begin
            state_d = ST_GRANT;
            owner_d = pick_idx;
            gnt_d   = N'(onehot(4'(pick_idx)));
            oe_d    = 1'b1;
            hold_d  = '0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            owner_q   <= '0;
            hold_q    <= '0;
            turn_q    <= '0;
            gnt_q     <= '0;
            oe_q      <= 1'b0;
            preempt_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            owner_q   <= owner_d;
            hold_q    <= hold_d;
            turn_q    <= turn_d;
            gnt_q     <= gnt_d;
            oe_q      <= oe_d;
            preempt_q <= preempt_d;
        end
    end

    assign o_gnt      = gnt_q;
    assign o_bus_oe   = oe_q;
    assign o_bus_data = oe_q ? i_wdata[owner_q*W +: W] : '0;
    assign o_owner    = owner_q;
    assign o_preempt  = preempt_q;
    assign o_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_shared_bus_arbiter.sv
// Bench for shared_bus_arbiter: two instances (turnaround 1 and 3) share the
// stimulus; a transaction-level model checks both every cycle.
module tb_shared_bus_arbiter;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic [3:0]  i_req;
    logic [3:0]  i_last;
    logic [39:0] i_wdata;

    logic [3:0] gnt_a, gnt_b;
    logic       oe_a, oe_b;
    logic [9:0] data_a, data_b;
    logic [1:0] own_a, own_b;
    logic       pre_a, pre_b, busy_a, busy_b;

    int checks   = 0;
    int failures = 0;

    shared_bus_arbiter #(.N(4), .W(10), .TURN_CYCLES(1), .MAX_HOLD(16)) dut_a (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_last(i_last), .i_wdata(i_wdata),
        .o_gnt(gnt_a), .o_bus_oe(oe_a), .o_bus_data(data_a), .o_owner(own_a),
        .o_preempt(pre_a), .o_busy(busy_a)
    );

    shared_bus_arbiter #(.N(4), .W(10), .TURN_CYCLES(3), .MAX_HOLD(16)) dut_b (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_last(i_last), .i_wdata(i_wdata),
        .o_gnt(gnt_b), .o_bus_oe(oe_b), .o_bus_data(data_b), .o_owner(own_b),
        .o_preempt(pre_b), .o_busy(busy_b)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: phase 0 idle, 1 owned, 2 dead time. held counts granted cycles
    // from 1, dead counts remaining undriven cycles down to 1.
    int m_tc[2]    = '{1, 3};
    int m_phase[2] = '{0, 0};
    int m_owner[2] = '{0, 0};
    int m_ptr[2]   = '{0, 0};
    int m_held[2]  = '{0, 0};
    int m_dead[2]  = '{0, 0};
    bit m_pre[2]   = '{0, 0};

    function automatic int pick(input logic [3:0] r, input int p);
        for (int i = 0; i < 4; i++)
            if (r[(p + i) % 4]) return (p + i) % 4;
        return -1;
    endfunction

    task automatic model_reset();
        for (int j = 0; j < 2; j++) begin
            m_phase[j] = 0; m_owner[j] = 0; m_ptr[j] = 0;
            m_held[j] = 0; m_dead[j] = 0; m_pre[j] = 0;
        end
    endtask

    task automatic model_grant(input int j);
        int k;
        k = pick(i_req, m_ptr[j]);
        if (k >= 0) begin
            m_phase[j] = 1; m_owner[j] = k; m_held[j] = 1;
        end else begin
            m_phase[j] = 0;
        end
    endtask

    task automatic model_step(input int j);
        int o;
        m_pre[j] = 0;
        o = m_owner[j];
        if (m_phase[j] == 0) begin
            model_grant(j);
        end else if (m_phase[j] == 1) begin
            if (!i_req[o] || i_last[o] || m_held[j] == 16) begin
                m_pre[j]   = i_req[o] && !i_last[o];
                m_ptr[j]   = (o + 1) % 4;
                m_phase[j] = 2;
                m_dead[j]  = m_tc[j];
            end else begin
                m_held[j]++;
            end
        end else begin
            if (m_dead[j] == 1) model_grant(j);
            else m_dead[j]--;
        end
    endtask

    task automatic cmp(input int j, input logic [3:0] g, input logic oe, input logic [9:0] d,
                       input logic [1:0] ow, input logic pr, input logic bs);
        logic [3:0] eg;
        logic [9:0] ed;
        eg = (m_phase[j] == 1) ? 4'(1 << m_owner[j]) : 4'b0000;
        ed = (m_phase[j] == 1) ? i_wdata[m_owner[j]*10 +: 10] : 10'h000;
        chk($sformatf("model%0d gnt", j), 32'(g), 32'(eg));
        chk($sformatf("model%0d oe", j), 32'(oe), 32'(eg != 4'b0000));
        chk($sformatf("model%0d data", j), 32'(d), 32'(ed));
        chk($sformatf("model%0d owner", j), 32'(ow), 32'(m_owner[j]));
        chk($sformatf("model%0d preempt", j), 32'(pr), 32'(m_pre[j]));
        chk($sformatf("model%0d busy", j), 32'(bs), 32'(m_phase[j] != 0));
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge i_clk or posedge i_rst);
            if (i_rst) model_reset();
            else begin
                model_step(0);
                model_step(1);
            end
        end
    end

    initial begin
        forever begin
            @(posedge i_clk);
            #1;
            cmp(0, gnt_a, oe_a, data_a, own_a, pre_a, busy_a);
            cmp(1, gnt_b, oe_b, data_b, own_b, pre_b, busy_b);
        end
    end

    initial begin
        int held;
        logic [3:0] exp_g;

        i_rst   = 1'b1;
        i_req   = 4'b1111;
        i_last  = 4'b0000;
        i_wdata = {10'h0F0, 10'h2AA, 10'h155, 10'h3A1};
        repeat (3) @(negedge i_clk);
        chk("reset gnt", 32'(gnt_a), 32'h0);
        chk("reset oe", 32'(oe_a), 32'h0);
        chk("reset data", 32'(data_a), 32'h0);
        chk("reset owner", 32'(own_a), 32'h0);
        chk("reset preempt", 32'(pre_a), 32'h0);
        chk("reset busy", 32'(busy_a), 32'h0);
        i_rst = 1'b0;

        @(negedge i_clk);
        chk("first grant gnt", 32'(gnt_a), 32'h1);
        chk("first grant oe", 32'(oe_a), 32'h1);
        chk("first grant data", 32'(data_a), 32'h3A1);
        i_req = 4'b0101;
        @(negedge i_clk);
        chk("r0 beat2 gnt", 32'(gnt_a), 32'h1);
        @(negedge i_clk);
        i_last = 4'b0001;
        @(negedge i_clk);
        chk("r0 last turn gnt", 32'(gnt_a), 32'h0);
        chk("r0 last turn oe", 32'(oe_a), 32'h0);
        i_last = 4'b0000;
        @(negedge i_clk);
        chk("next owner gnt", 32'(gnt_a), 32'h4);
        chk("next owner idx", 32'(own_a), 32'h2);
        chk("next owner data", 32'(data_a), 32'h2AA);

        i_req  = 4'b0110;
        i_last = 4'b0100;
        @(negedge i_clk);
        i_last = 4'b0000;
        @(negedge i_clk);
        held = 0;
        while (gnt_a == 4'b0010 && held < 40) begin
            held++;
            i_wdata[19:10] = 10'(held);
            @(negedge i_clk);
        end
        chk("hold limit cycles", 32'(held), 32'd16);
        chk("hold limit preempt", 32'(pre_a), 32'h1);
        chk("hold limit gnt", 32'(gnt_a), 32'h0);
        @(negedge i_clk);
        chk("after preempt gnt", 32'(gnt_a), 32'h4);
        chk("after preempt owner", 32'(own_a), 32'h2);
        chk("preempt pulse width", 32'(pre_a), 32'h0);

        i_req = 4'b1000;
        @(negedge i_clk);
        chk("abandon gnt", 32'(gnt_a), 32'h0);
        @(negedge i_clk);
        chk("owner3 gnt", 32'(gnt_a), 32'h8);
        chk("owner3 idx", 32'(own_a), 32'h3);
        @(negedge i_clk);
        chk("owner3 beat2", 32'(gnt_a), 32'h8);
        i_req = 4'b0000;
        @(negedge i_clk);
        chk("owner3 drop oe", 32'(oe_a), 32'h0);
        chk("owner3 drop busy", 32'(busy_a), 32'h1);
        chk("owner3 drop preempt", 32'(pre_a), 32'h0);
        i_req = 4'b1001;
        @(negedge i_clk);
        chk("ptr wrap gnt", 32'(gnt_a), 32'h1);

        i_req  = 4'b0011;
        i_last = 4'b0001;
        @(negedge i_clk);
        i_last = 4'b0000;
        @(negedge i_clk);
        chk("pre-reset owner1", 32'(gnt_a), 32'h2);
        @(negedge i_clk);
        chk("pre-reset cycle2", 32'(gnt_a), 32'h2);
        #2;
        i_rst = 1'b1;
        #1;
        chk("async reset gnt", 32'(gnt_a), 32'h0);
        chk("async reset oe", 32'(oe_a), 32'h0);
        chk("async reset data", 32'(data_a), 32'h0);
        chk("async reset busy", 32'(busy_a), 32'h0);
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        chk("post-reset ptr0 gnt", 32'(gnt_a), 32'h1);

        i_rst  = 1'b1;
        i_req  = 4'b1111;
        i_last = 4'b1111;
        @(negedge i_clk);
        i_rst = 1'b0;
        for (int c = 0; c < 17; c++) begin
            @(negedge i_clk);
            exp_g = (c % 4 == 0) ? 4'(1 << ((c / 4) % 4)) : 4'b0000;
            chk($sformatf("turn3 rotate c%0d", c), 32'(gnt_b), 32'(exp_g));
        end

        @(negedge i_clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
